// File: rtl/display_scan_ctrl.sv
// Scan/mode sequencer for the 6-digit clock display: digit scan index, page mux,
// mode FSM with idle timeout, and blink gating of the field under edit.
module display_scan_ctrl #(
  parameter int SCAN_DIV      = 50000,
  parameter int BLINK_SLOTS   = 500,
  parameter int TIMEOUT_SLOTS = 30000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_key,
  input  logic       edit_key,
  input  logic [6:0] time_hour,
  input  logic [6:0] time_min,
  input  logic [6:0] time_sec,
  input  logic [6:0] alarm_hour,
  input  logic [6:0] alarm_min,
  output logic [6:0] hour,
  output logic [6:0] min,
  output logic [6:0] sec,
  output logic [3:0] selct,
  output logic [1:0] edit_field,
  output logic       blank
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam int TW = $clog2(TIMEOUT_SLOTS + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SLOTS - 1);
  localparam logic [TW-1:0] TO_LIMIT   = TW'(TIMEOUT_SLOTS);

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    SET_HOUR   = 3'd1,
    SET_MIN    = 3'd2,
    SET_SEC    = 3'd3,
    SHOW_ALARM = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q;
  logic [3:0]      sel_q;
  logic [BW-1:0]   blink_cnt_q;
  logic            blink_phase_q;
  logic [TW-1:0]   to_q;
  logic [1:0]      edit_q;
  logic [6:0]      hour_q, min_q, sec_q;
  logic            slot_tick, timeout_hit, state_chg;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      SET_HOUR: return 2'd1;
      SET_MIN:  return 2'd2;
      SET_SEC:  return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

  assign slot_tick   = (pre_q == PRE_LAST);
  assign timeout_hit = (to_q == TO_LIMIT);

  // mode_key has priority over the idle timeout
  always_comb begin
    state_d = state_q;
    if (mode_key) begin
      case (state_q)
        SHOW_TIME: state_d = SET_HOUR;
        SET_HOUR:  state_d = SET_MIN;
        SET_MIN:   state_d = SET_SEC;
        SET_SEC:   state_d = SHOW_ALARM;
        default:   state_d = SHOW_TIME;
      endcase
    end else if (timeout_hit && state_q != SHOW_TIME) begin
      state_d = SHOW_TIME;
    end
  end

  assign state_chg = (state_d != state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SHOW_TIME;
      pre_q         <= '0;
      sel_q         <= 4'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      to_q          <= '0;
      edit_q        <= 2'd0;
      hour_q        <= 7'd0;
      min_q         <= 7'd0;
      sec_q         <= 7'd0;
    end else begin
      pre_q <= slot_tick ? '0 : pre_q + PW'(1);
      if (slot_tick) sel_q <= (sel_q == 4'd5) ? 4'd0 : sel_q + 4'd1;

      state_q <= state_d;
      edit_q  <= field_of(state_d);

      if (state_q == SHOW_ALARM) begin
        hour_q <= sat99(alarm_hour);
        min_q  <= sat99(alarm_min);
        sec_q  <= 7'd0;
      end else begin
        hour_q <= sat99(time_hour);
        min_q  <= sat99(time_min);
        sec_q  <= sat99(time_sec);
      end

      // Restarting blink on entry keeps the edited field visible first
      if (state_chg) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b0;
      end else if (slot_tick) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end

      if (mode_key || edit_key || state_chg)
        to_q <= '0;
      else if (slot_tick && state_q != SHOW_TIME && !timeout_hit)
        to_q <= to_q + TW'(1);
    end
  end

  assign hour       = hour_q;
  assign min        = min_q;
  assign sec        = sec_q;
  assign selct      = sel_q;
  assign edit_field = edit_q;
  // sel_q[3:1] names the digit pair: 0 -> min, 1 -> hour, 2 -> sec
  assign blank = blink_phase_q &
                 (((state_q == SET_HOUR) && (sel_q[3:1] == 3'd1)) ||
                  ((state_q == SET_MIN)  && (sel_q[3:1] == 3'd0)) ||
                  ((state_q == SET_SEC)  && (sel_q[3:1] == 3'd2)));

endmodule
